// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - byte-stream program loader for the instruction store
//
// Purpose: receives a program image as a byte stream (in_valid/in_ready),
//   assembles little-endian DATA_W-bit instruction words and writes them into
//   the instruction memory write port, holding the CPU in reset while busy.
//   Stream: header (word count minus 1, little-endian, ceil(ADDR_W/8) bytes),
//   then N words of ceil(DATA_W/8) bytes each, little-endian.
// Optional feature: define PROG_LOADER_CHECKSUM_EN to expect one trailing
//   checksum byte (XOR of all header and data bytes); a mismatch sets err.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   start                 one-cycle pulse, begins a load when idle
//   in_data/in_valid      stream byte and its qualifier
//   in_ready              byte accepted when in_valid & in_ready
//   mem_we/mem_addr/      one-cycle write strobe, address and word
//     mem_wdata
//   cpu_hold, busy        high while a load is in progress
//   done                  one-cycle pulse in the final (FIN) cycle
//   err                   sticky checksum error (0 without the feature)
module prog_loader #(
  parameter int DATA_W = 37,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int BPW   = (DATA_W + 7) / 8;
  localparam int HDR_B = (ADDR_W + 7) / 8;
  localparam int MAXB  = (BPW > HDR_B) ? BPW : HDR_B;
  localparam int CNT_W = $clog2(MAXB + 1);

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_DATA, S_CSUM, S_FIN} state_t;

  state_t            state;
  logic [CNT_W-1:0]  byte_cnt;
  logic [ADDR_W-1:0] widx;
  logic [ADDR_W-1:0] last_idx;
  logic [ADDR_W-1:0] hdr_buf;
  logic [DATA_W-1:0] word_buf;
  logic              last_wr;   // final word written; FIN follows next cycle
  logic              accept;
  logic [ADDR_W-1:0] hdr_next;
  logic [DATA_W-1:0] word_next;

  assign accept   = in_valid & in_ready;
  assign cpu_hold = busy;

  // Merge the incoming byte into the partially assembled header/word. Only
  // bits that exist in the destination are kept, so the top bits of the last
  // byte of a word fall away here.
  always_comb begin
    hdr_next  = hdr_buf;
    word_next = word_buf;
    for (int j = 0; j < ADDR_W; j++) begin
      if (CNT_W'(j / 8) == byte_cnt) hdr_next[j] = in_data[j % 8];
    end
    for (int j = 0; j < DATA_W; j++) begin
      if (CNT_W'(j / 8) == byte_cnt) word_next[j] = in_data[j % 8];
    end
  end

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0] csum;
  logic       err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      byte_cnt  <= '0;
      widx      <= '0;
      last_idx  <= '0;
      hdr_buf   <= '0;
      word_buf  <= '0;
      last_wr   <= 1'b0;
      in_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum      <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      mem_we <= 1'b0;
      done   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_HDR;
            busy     <= 1'b1;
            in_ready <= 1'b1;
            byte_cnt <= '0;
            widx     <= '0;
            last_wr  <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum     <= '0;
            err_q    <= 1'b0;
`endif
          end
        end

        S_HDR: begin
          if (accept) begin
            hdr_buf <= hdr_next;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum    <= csum ^ in_data;
`endif
            if (byte_cnt == CNT_W'(HDR_B - 1)) begin
              byte_cnt <= '0;
              last_idx <= hdr_next;
              state    <= S_DATA;
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
            end
          end
        end

        S_DATA: begin
          if (last_wr) begin
            // mem_we for the final word was high last cycle; finish now
            last_wr <= 1'b0;
            state   <= S_FIN;
            done    <= 1'b1;
          end else if (accept) begin
            word_buf <= word_next;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum     <= csum ^ in_data;
`endif
            if (byte_cnt == CNT_W'(BPW - 1)) begin
              byte_cnt  <= '0;
              mem_we    <= 1'b1;
              mem_addr  <= widx;
              mem_wdata <= word_next;
              widx      <= widx + 1'b1;
              // widx may wrap after the last word; it is never used again
              if (widx == last_idx) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                state    <= S_CSUM;
`else
                in_ready <= 1'b0;
                last_wr  <= 1'b1;
`endif
              end
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
            end
          end
        end

`ifdef PROG_LOADER_CHECKSUM_EN
        S_CSUM: begin
          if (accept) begin
            in_ready <= 1'b0;
            state    <= S_FIN;
            done     <= 1'b1;
            if (in_data != csum) err_q <= 1'b1;
          end
        end
`endif

        S_FIN: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state    <= S_IDLE;
          busy     <= 1'b0;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - self-checking bench for prog_loader
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready, mem_we, cpu_hold, busy, done, err;
  logic [7:0]  mem_addr;
  logic [36:0] mem_wdata;

  prog_loader #(.DATA_W(37), .ADDR_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_hold(cpu_hold),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0]  addr;
    logic [36:0] data;
  } wr_t;

  typedef struct {
    logic [39:0] bytes;   // byte 0 in bits [7:0]
    logic [36:0] exp;
  } vec_t;

  wr_t        wq[$];
  logic [7:0] prog[$];
  int cyc = 0;
  int last_we_cyc = -10;
  int done_cnt = 0;
  int done_late = 0;
  int idle_rdy = 0;
  int hold_bad = 0;
  int err_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_we) begin
      wq.push_back({mem_addr, mem_wdata});
      last_we_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
`ifndef PROG_LOADER_CHECKSUM_EN
      if (cyc != last_we_cyc + 1) done_late++;
`endif
    end
    if (!busy && in_ready) idle_rdy++;
    if (cpu_hold !== busy) hold_bad++;
    if (err) err_seen++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int t;
    t = 0;
    in_data  = b;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      t++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready 0 expected 1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: got busy 1 expected 0");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_prog(input bit gap, input bit corrupt);
    logic [7:0] x;
    x = 8'h00;
    foreach (prog[i]) begin
      send_byte(prog[i], gap);
      x ^= prog[i];
    end
`ifdef PROG_LOADER_CHECKSUM_EN
    send_byte(x ^ (corrupt ? 8'h01 : 8'h00), 1'b0);
`else
    if (corrupt && x == 8'h00) x = 8'h01;
`endif
  endtask

  task automatic run_load(input bit gap, input bit corrupt);
    pulse_start();
    send_prog(gap, corrupt);
    wait_idle();
  endtask

  vec_t vecs[4];

  initial begin
    int base, dc0, bad;
    logic [7:0]  k;
    logic [36:0] e;

    vecs[0] = '{40'h00_0000_0041, 37'h00_0000_0041};
    vecs[1] = '{40'hFF_1234_5678, 37'h1F_1234_5678};  // FF top byte -> 5'b11111
    vecs[2] = '{40'h20_DEAD_BEEF, 37'h00_DEAD_BEEF};  // only bit 5 set -> dropped
    vecs[3] = '{40'h15_0000_0001, 37'h15_0000_0001};

    // reset state, checked while reset is held and after release
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ready_we_done", 64'({in_ready, mem_we, done, cpu_hold}), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_addr_data", 64'({mem_addr, mem_wdata}), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    @(posedge clk);
    #1;

    // test 1: single word, busy rises the cycle after start, done after mem_we
    dc0 = done_cnt;
    base = wq.size();
    chk("t1_busy_before", 64'(busy), 64'd0);
    start = 1'b1;
    @(negedge clk);
    chk("t1_busy_same_cycle", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("t1_busy_rise", 64'(busy), 64'd1);
    prog = '{8'h00, 8'h41, 8'h00, 8'h00, 8'h00, 8'h00};
    send_prog(1'b0, 1'b0);
    wait_idle();
    chk("t1_we_count", 64'(wq.size() - base), 64'd1);
    if (wq.size() > base) begin
      chk("t1_addr", 64'(wq[base].addr), 64'd0);
      chk("t1_data", 64'(wq[base].data), 64'h41);
    end
    chk("t1_done_count", 64'(done_cnt - dc0), 64'd1);
    chk("t1_busy_end", 64'(busy), 64'd0);

    // tests 2/3: table of four words, in_valid toggling every other cycle
    base = wq.size();
    prog = '{8'h03};
    foreach (vecs[i]) for (int b = 0; b < 5; b++) prog.push_back(vecs[i].bytes[8*b +: 8]);
    run_load(1'b1, 1'b0);
    chk("t2_we_count", 64'(wq.size() - base), 64'd4);
    for (int i = 0; i < 4; i++) begin
      if (base + i < wq.size()) begin
        chk($sformatf("t2_addr%0d", i), 64'(wq[base+i].addr), 64'(i));
        chk($sformatf("t2_data%0d", i), 64'(wq[base+i].data), 64'(vecs[i].exp));
      end
    end

    // start while busy is ignored: a second start mid-load must not restart
    base = wq.size();
    pulse_start();
    send_byte(8'h01, 1'b0);
    for (int b = 0; b < 3; b++) send_byte(8'h10 + 8'(b), 1'b0);
    pulse_start();
    send_byte(8'h13, 1'b0);
    send_byte(8'h14, 1'b0);
    for (int b = 0; b < 5; b++) send_byte(8'h20 + 8'(b), 1'b0);
`ifdef PROG_LOADER_CHECKSUM_EN
    send_byte(8'h01 ^ 8'h10 ^ 8'h11 ^ 8'h12 ^ 8'h13 ^ 8'h14 ^
              8'h20 ^ 8'h21 ^ 8'h22 ^ 8'h23 ^ 8'h24, 1'b0);
`endif
    wait_idle();
    chk("t2b_we_count", 64'(wq.size() - base), 64'd2);
    if (wq.size() >= base + 2) begin
      chk("t2b_data0", 64'(wq[base].data), 64'h14_1312_1110);
      chk("t2b_addr1", 64'(wq[base+1].addr), 64'd1);
      chk("t2b_data1", 64'(wq[base+1].data), 64'h04_2322_2120);
    end

    // test 4: header FF -> 256 words, addresses 0..FF, no wrap
    base = wq.size();
    prog = '{8'hFF};
    for (int w = 0; w < 256; w++) begin
      k = 8'(w);
      prog.push_back(k);
      prog.push_back(~k);
      prog.push_back(8'hC3);
      prog.push_back(k);
      prog.push_back(8'hE7);
    end
    run_load(1'b0, 1'b0);
    chk("t4_we_count", 64'(wq.size() - base), 64'd256);
    bad = 0;
    for (int w = 0; w < 256 && base + w < wq.size(); w++) begin
      k = 8'(w);
      e = {5'h07, k, 8'hC3, ~k, k};
      if (wq[base+w].addr !== k || wq[base+w].data !== e) bad++;
    end
    chk("t4_word_mismatches", 64'(bad), 64'd0);
    if (wq.size() > 0) chk("t4_last_addr", 64'(wq[wq.size()-1].addr), 64'hFF);

    // test 5: reset after 7 data bytes
    base = wq.size();
    pulse_start();
    send_byte(8'h01, 1'b0);
    foreach (vecs[0].bytes[i]) begin end
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b0);
    send_byte(8'h55, 1'b0);
    send_byte(8'h66, 1'b0);
    send_byte(8'h77, 1'b0);
    chk("t5_pre_we_count", 64'(wq.size() - base), 64'd1);
    if (wq.size() > base) chk("t5_pre_data", 64'(wq[base].data), 64'h15_4433_2211);
    rst = 1'b1;
    #1;
    chk("t5_rst_busy_ready", 64'({busy, cpu_hold, in_ready, mem_we, done}), 64'd0);
    chk("t5_rst_addr_data", 64'({mem_addr, mem_wdata}), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    base = wq.size();
    prog = '{8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h0E};
    run_load(1'b0, 1'b0);
    chk("t5_post_we_count", 64'(wq.size() - base), 64'd1);
    if (wq.size() > base) begin
      chk("t5_post_addr", 64'(wq[base].addr), 64'd0);
      chk("t5_post_data", 64'(wq[base].data), 64'h0E_DDCC_BBAA);
    end

    // test 6: checksum behaviour
    prog = '{8'h00, 8'h41, 8'h00, 8'h00, 8'h00, 8'h00};
`ifdef PROG_LOADER_CHECKSUM_EN
    run_load(1'b0, 1'b0);
    chk("t6_err_good", 64'(err), 64'd0);
    dc0 = done_cnt;
    run_load(1'b0, 1'b1);
    chk("t6_err_bad", 64'(err), 64'd1);
    chk("t6_done_on_bad", 64'(done_cnt - dc0), 64'd1);
    pulse_start();
    chk("t6_err_cleared", 64'(err), 64'd0);
    send_prog(1'b0, 1'b0);
    wait_idle();
`else
    run_load(1'b0, 1'b1);
    chk("t6_err_never", 64'(err_seen), 64'd0);
`endif

    // whole-run properties
    chk("idle_in_ready", 64'(idle_rdy), 64'd0);
    chk("cpu_hold_eq_busy", 64'(hold_bad), 64'd0);
    chk("done_after_we", 64'(done_late), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
